// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side and serial-line signals of the UART transmitter, bundled.
// slave: the transmitter (consumes FIFO status/data, drives pop and line).
// master: the FIFO/host side (drives FIFO status/data, observes pop and line).
interface fifo_uart_tx_if;
  logic        i_tx_en;
  logic        i_buf_empty;
  logic [7:0]  i_buf_out;
  logic        o_rd_en;
  logic        o_tx;
  logic        o_busy;
  logic [15:0] o_frame_cnt;

  modport slave (
    input  i_tx_en, i_buf_empty, i_buf_out,
    output o_rd_en, o_tx, o_busy, o_frame_cnt
  );

  modport master (
    output i_tx_en, i_buf_empty, i_buf_out,
    input  o_rd_en, o_tx, o_busy, o_frame_cnt
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO and sends each byte as an 8N1 serial frame on o_tx.
// Latency: pop 1 cycle after the IDLE sample, start bit 3 cycles after it.
// Backpressure: one byte in flight; no pop until the current frame ends.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  fifo_uart_tx_if.slave     bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_baud_cnt;
  logic [CW-1:0]   w_baud_nxt;
  logic [2:0]      r_bit_idx;
  logic [2:0]      w_bit_idx_nxt;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_nxt;
  logic [15:0]     r_frame_cnt;
  logic            r_tx;
  logic            r_rd_en;
  logic            w_tx_nxt;
  logic            w_rd_en_nxt;
  logic            w_baud_last;

  assign w_baud_last = (r_baud_cnt == BAUD_LAST);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; tx_en/buf_empty only matter while idle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.i_tx_en && !bus.i_buf_empty) w_state_nxt = S_FETCH;
      S_FETCH: w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_START;
      S_START: if (w_baud_last) w_state_nxt = S_DATA;
      S_DATA:  if (w_baud_last && (r_bit_idx == 3'd7)) w_state_nxt = S_STOP;
      S_STOP:  if (w_baud_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath next values: baud counter, bit index and shift register.
  always_comb begin
    w_baud_nxt    = '0;
    w_bit_idx_nxt = '0;
    w_shift_nxt   = r_shift;

    // Baud counter restarts on every state change, including bit-to-stop.
    if ((w_state_nxt == r_state) &&
        ((r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP))) begin
      w_baud_nxt = w_baud_last ? '0 : r_baud_cnt + 1'b1;
    end

    if (r_state == S_DATA) begin
      w_bit_idx_nxt = w_baud_last ? r_bit_idx + 3'd1 : r_bit_idx;
    end

    // buf_out is valid during LOAD (FIFO registered it on the FETCH edge).
    if (r_state == S_LOAD) begin
      w_shift_nxt = bus.i_buf_out;
    end else if ((r_state == S_DATA) && w_baud_last) begin
      w_shift_nxt = {1'b0, r_shift[7:1]};
    end
  end

  // Output decode from the upcoming state so tx/rd_en can be registered.
  always_comb begin
    w_rd_en_nxt = (w_state_nxt == S_FETCH);
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  // Datapath and completed-frame counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_baud_cnt  <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_baud_cnt <= w_baud_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shift    <= w_shift_nxt;
      if ((r_state == S_STOP) && w_baud_last) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  // Registered line and pop outputs; no combinational path from inputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx    <= 1'b1;
      r_rd_en <= 1'b0;
    end else begin
      r_tx    <= w_tx_nxt;
      r_rd_en <= w_rd_en_nxt;
    end
  end

  assign bus.o_tx        = r_tx;
  assign bus.o_rd_en     = r_rd_en;
  assign bus.o_busy      = (r_state != S_IDLE);
  assign bus.o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with CLKS_PER_BIT=4 and a small FIFO model.
// The FIFO registers read data on the edge that samples rd_en.
// Outputs are sampled on the falling clock edge.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic clk;
  logic rst;

  fifo_uart_tx_if ifc ();

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifc)
  );

  int checks = 0;
  int fails  = 0;

  logic [7:0] mem [0:15];
  int pushes = 0;
  int pops   = 0;
  int rd_pulses = 0;
  int rd_dbl    = 0;
  logic prev_rd = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ifc.i_buf_empty = (pushes == pops);

  // FIFO read port model plus rd_en pulse monitor.
  always @(posedge clk) begin
    if (ifc.o_rd_en === 1'b1) begin
      rd_pulses++;
      if (prev_rd) rd_dbl++;
      if (pops != pushes) begin
        ifc.i_buf_out <= mem[pops % 16];
        pops++;
      end
    end
    prev_rd = (ifc.o_rd_en === 1'b1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    mem[pushes % 16] = b;
    pushes++;
  endtask

  task automatic test_reset();
    int p0;
    rst = 1'b1;
    ifc.i_tx_en = 1'b1;
    push(8'hA5);
    tick();
    p0 = rd_pulses;
    tick();
    tick();
    checks++; if (ifc.o_tx !== 1'b1) begin fails++; $display("FAIL reset_tx got %b want 1", ifc.o_tx); end
    checks++; if (ifc.o_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en got %b want 0", ifc.o_rd_en); end
    checks++; if (ifc.o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", ifc.o_busy); end
    checks++; if (ifc.o_frame_cnt !== 16'd0) begin fails++; $display("FAIL reset_frame_cnt got %0d want 0", ifc.o_frame_cnt); end
    checks++; if (rd_pulses != p0) begin fails++; $display("FAIL reset_no_pop got %0d pulses want 0", rd_pulses - p0); end
  endtask

  task automatic test_single_byte();
    logic [9:0] exp;
    int n;
    int p0;
    exp = 10'b1_1010_0101_0;   // stop, 0xA5, start (index 0 = first bit time)
    p0 = rd_pulses;
    rst = 1'b0;
    n = 0;
    while (ifc.o_rd_en !== 1'b1 && n < 50) begin tick(); n++; end
    checks++; if (ifc.o_rd_en !== 1'b1) begin fails++; $display("FAIL single_rd_en timeout got %b want 1", ifc.o_rd_en); end
    tick();
    checks++; if (ifc.o_rd_en !== 1'b0) begin fails++; $display("FAIL single_rd_en_width got %b want 0", ifc.o_rd_en); end
    checks++; if (ifc.o_tx !== 1'b1) begin fails++; $display("FAIL single_tx_before_start got %b want 1", ifc.o_tx); end
    tick();
    for (int i = 0; i < 10 * CPB; i++) begin
      checks++;
      if (ifc.o_tx !== exp[i / CPB]) begin
        fails++; $display("FAIL single_tx cycle %0d got %b want %b", i, ifc.o_tx, exp[i / CPB]);
      end
      tick();
    end
    checks++; if (ifc.o_frame_cnt !== 16'd1) begin fails++; $display("FAIL single_frame_cnt got %0d want 1", ifc.o_frame_cnt); end
    checks++; if (ifc.o_busy !== 1'b0) begin fails++; $display("FAIL single_busy got %b want 0", ifc.o_busy); end
    checks++; if (rd_pulses - p0 != 1) begin fails++; $display("FAIL single_pulses got %0d want 1", rd_pulses - p0); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp1;
    logic [9:0] exp2;
    int n;
    int p0;
    exp1 = 10'b1_0000_0000_0;
    exp2 = 10'b1_1111_1111_0;
    p0 = rd_pulses;
    push(8'h00);
    push(8'hFF);
    n = 0;
    while (ifc.o_rd_en !== 1'b1 && n < 50) begin tick(); n++; end
    checks++; if (ifc.o_rd_en !== 1'b1) begin fails++; $display("FAIL b2b_rd_en timeout got %b want 1", ifc.o_rd_en); end
    tick();
    tick();
    // Start bit and data bits of frame 1; the stop bit is covered by the gap count.
    for (int i = 0; i < 9 * CPB; i++) begin
      checks++;
      if (ifc.o_tx !== exp1[i / CPB]) begin
        fails++; $display("FAIL b2b_frame1 cycle %0d got %b want %b", i, ifc.o_tx, exp1[i / CPB]);
      end
      tick();
    end
    n = 0;
    while (ifc.o_tx === 1'b1 && n < 40) begin n++; tick(); end
    checks++; if (n != CPB + 3) begin fails++; $display("FAIL b2b_gap got %0d high cycles want %0d", n, CPB + 3); end
    for (int i = 0; i < 10 * CPB; i++) begin
      checks++;
      if (ifc.o_tx !== exp2[i / CPB]) begin
        fails++; $display("FAIL b2b_frame2 cycle %0d got %b want %b", i, ifc.o_tx, exp2[i / CPB]);
      end
      tick();
    end
    checks++; if (ifc.o_frame_cnt !== 16'd3) begin fails++; $display("FAIL b2b_frame_cnt got %0d want 3", ifc.o_frame_cnt); end
    checks++; if (rd_pulses - p0 != 2) begin fails++; $display("FAIL b2b_pulses got %0d want 2", rd_pulses - p0); end
  endtask

  task automatic test_flow_control();
    int bad;
    int n;
    int p0;
    ifc.i_tx_en = 1'b0;
    push(8'h5A);
    push(8'h77);
    p0 = rd_pulses;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ifc.o_rd_en !== 1'b0 || ifc.o_tx !== 1'b1) bad++;
    end
    checks++; if (bad != 0 || rd_pulses != p0) begin fails++; $display("FAIL flow_hold got %0d bad cycles %0d pulses want 0 0", bad, rd_pulses - p0); end
    ifc.i_tx_en = 1'b1;
    n = 0;
    while (ifc.o_rd_en !== 1'b1 && n < 50) begin tick(); n++; end
    checks++; if (ifc.o_rd_en !== 1'b1) begin fails++; $display("FAIL flow_rd_en timeout got %b want 1", ifc.o_rd_en); end
    // Advance into data bit 2 before dropping tx_en.
    for (int i = 0; i < 2 + 3 * CPB; i++) tick();
    checks++; if (ifc.o_busy !== 1'b1) begin fails++; $display("FAIL flow_busy_mid got %b want 1", ifc.o_busy); end
    ifc.i_tx_en = 1'b0;
    for (int i = 0; i < 10 * CPB - 2 * CPB; i++) tick();
    checks++; if (ifc.o_frame_cnt !== 16'd4) begin fails++; $display("FAIL flow_frame_cnt got %0d want 4", ifc.o_frame_cnt); end
    checks++; if (ifc.o_busy !== 1'b0) begin fails++; $display("FAIL flow_busy_end got %b want 0", ifc.o_busy); end
    for (int i = 0; i < 30; i++) tick();
    checks++; if (rd_pulses - p0 != 1) begin fails++; $display("FAIL flow_no_refetch got %0d pulses want 1", rd_pulses - p0); end
    checks++; if (ifc.o_tx !== 1'b1) begin fails++; $display("FAIL flow_tx_idle got %b want 1", ifc.o_tx); end
  endtask

  // 0x77 is still queued from the flow-control test; its bit 3 is 0.
  task automatic test_reset_mid_data();
    logic [9:0] exp;
    int n;
    int p0;
    exp = 10'b1_1000_0001_0;
    push(8'h81);
    ifc.i_tx_en = 1'b1;
    n = 0;
    while (ifc.o_rd_en !== 1'b1 && n < 50) begin tick(); n++; end
    checks++; if (ifc.o_rd_en !== 1'b1) begin fails++; $display("FAIL rstmid_rd_en timeout got %b want 1", ifc.o_rd_en); end
    for (int i = 0; i < 2 + CPB + 3 * CPB; i++) tick();
    checks++; if (ifc.o_tx !== 1'b0) begin fails++; $display("FAIL rstmid_bit3 got %b want 0", ifc.o_tx); end
    rst = 1'b1;
    tick();
    checks++; if (ifc.o_tx !== 1'b1) begin fails++; $display("FAIL rstmid_tx got %b want 1", ifc.o_tx); end
    checks++; if (ifc.o_frame_cnt !== 16'd0) begin fails++; $display("FAIL rstmid_frame_cnt got %0d want 0", ifc.o_frame_cnt); end
    checks++; if (ifc.o_busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", ifc.o_busy); end
    p0 = rd_pulses;
    rst = 1'b0;
    n = 0;
    while (ifc.o_rd_en !== 1'b1 && n < 50) begin tick(); n++; end
    checks++; if (ifc.o_rd_en !== 1'b1) begin fails++; $display("FAIL rstmid_refetch timeout got %b want 1", ifc.o_rd_en); end
    tick();
    tick();
    for (int i = 0; i < 10 * CPB; i++) begin
      checks++;
      if (ifc.o_tx !== exp[i / CPB]) begin
        fails++; $display("FAIL rstmid_frame cycle %0d got %b want %b", i, ifc.o_tx, exp[i / CPB]);
      end
      tick();
    end
    checks++; if (ifc.o_frame_cnt !== 16'd1) begin fails++; $display("FAIL rstmid_frame_cnt_after got %0d want 1", ifc.o_frame_cnt); end
    checks++; if (rd_pulses - p0 != 1) begin fails++; $display("FAIL rstmid_pulses got %0d want 1", rd_pulses - p0); end
    checks++; if (pops != pushes) begin fails++; $display("FAIL rstmid_drained got %0d pops want %0d", pops, pushes); end
  endtask

  task automatic test_pop_spacing();
    checks++; if (rd_dbl != 0) begin fails++; $display("FAIL pop_spacing got %0d back-to-back rd_en want 0", rd_dbl); end
  endtask

  initial begin
    rst = 1'b1;
    ifc.i_tx_en = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_flow_control();
    test_reset_mid_data();
    test_pop_spacing();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
